running_light_multi: RTL and testbench
======================================

Name: running_light_multi

Overview:
- Parametrised, next-generation running-light driver: N_LED outputs, four selectable patterns, on-chip step prescaler, pause control and step strobe.
- Sits between the board clock and the LED bank. Intended for on-board bring-up and for simulation with a reduced TICK_DIV.
- Fully synchronous, one clock domain.

Parameters:
- N_LED, 8, number of LED outputs; legal range 2..32.
- TICK_DIV, 50, clk cycles per pattern step; must be >= 1 (1 = step every enabled cycle).
- CNT_W, $clog2(TICK_DIV+1), prescaler counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  1 = run, 0 = freeze prescaler and pattern.
- S  in  2  mode: 0 rotate-left, 1 rotate-right, 2 bounce, 3 fill/drain.
- Y  out  N_LED  LED pattern, registered.
- step  out  1  one-cycle pulse in the same cycle Y shows a new stepped value.

Behaviour:
- Reset: rst=1 at a clk edge wins over all other inputs. Reset state:
  - Y = {N_LED-1{0},1}, step=0
  - prescaler cnt=0
  - mode_q=0, dir=UP, level=0
- Mode register: mode_q holds the mode currently being played.
  - Each cycle with rst=0: if S != mode_q, then mode_q<=S, cnt<=0, step<=0, and Y/dir/level load the start state of S. This happens regardless of en.
  - A mode change takes priority over a tick in the same cycle.
- Start states:
  - mode0: Y=...0001
  - mode1: Y=1000...
  - mode2: Y=...0001, dir=UP
  - mode3: Y=0, level=0, dir=UP
- Prescaler (no mode change, en=1):
  - If cnt==TICK_DIV-1: cnt<=0 and a tick occurs, so Y advances and step<=1 on that edge.
  - Otherwise cnt<=cnt+1 and step<=0.
- en=0: cnt, Y, dir, level hold; step<=0. When en returns to 1, counting resumes from the held cnt (no restart).
- Step rules per mode (N = N_LED):
  - mode0: Y <= {Y[N-2:0],Y[N-1]}. Circular; MSB wraps to bit0.
  - mode1: Y <= {Y[0],Y[N-1:1]}. Circular; bit0 wraps to MSB.
  - mode2 bounce:
    - dir=UP: shift left. If the new Y has bit N-1 set, dir<=DOWN.
    - dir=DOWN: shift right. If the new Y has bit0 set, dir<=UP.
    - Period 2N-2 steps; end LEDs are lit for only one step per pass.
  - mode3 fill/drain: Y = (1<<level)-1, level in 0..N.
    - UP: level+1, and dir<=DOWN when level reaches N.
    - DOWN: level-1, and dir<=UP when level reaches 0.
    - Period 2N steps; all-ones and all-zeros each appear once per period.
- Latency:
  - First step after reset or a mode change occurs TICK_DIV enabled cycles after the load edge.
  - Y never changes except on a reset, a mode-change load, or a tick.
- Invariants:
  - Modes 0–2: Y is always one-hot.
  - Mode 3: Y is always a thermometer code.
  - Any illegal internal state (e.g. Y=0 in modes 0–2) must recover to the mode start state on the next tick.
- Arithmetic: cnt is unsigned CNT_W bits; level is $clog2(N+1) bits; no overflow is possible within the legal ranges.

Decomposition:
- Package running_light_pkg: mode constants MODE_ROL=2'd0, MODE_ROR=2'd1, MODE_BOUNCE=2'd2, MODE_FILL=2'd3; DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module light_prescaler (params TICK_DIV; ports clk, rst, clr, en, tick): holds the counter and wrap logic; clr is driven by a mode change.
- Pattern FSM and mode register live in running_light_multi.

Test Plan (N_LED=8, TICK_DIV=2 unless stated):
- Reset, S=0, en=1 → Y=01h, step=0 after reset. Y=02h,04h,…,80h,01h, one step every 2 clks, step pulses aligned with each Y change.
- S=1 from reset → load Y=80h on the next edge. Then 40h,20h,…,01h,80h; verify wrap.
- S=2 → 01,02,…,80,40,…,02,01,02; period 14 steps. 80h and 01h each appear for exactly one step per pass.
- S=3 → 00,01,03,07,0F,1F,3F,7F,FF,7F,…,01,00,01; period 16 steps.
- Mode 0 at Y=08h: drop en for 5 cycles → Y and step held. S changes to 3 mid-count while en=0 → Y=00h next edge, cnt cleared. en=1 → first step after exactly 2 cycles.
- rst asserted mid-bounce with dir=DOWN, together with a tick → Y=01h, dir=UP, step=0. Repeat the basic run with TICK_DIV=1 → Y steps every enabled cycle.

Source files
------------

// File: rtl/running_light_pkg.sv
// rtl/running_light_pkg.sv - shared mode and direction encodings for the running-light driver
package running_light_pkg;

   typedef enum logic [1:0] {
      MODE_ROL    = 2'd0,
      MODE_ROR    = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/light_prescaler.sv
// rtl/light_prescaler.sv - step prescaler: one tick every TICK_DIV enabled cycles
module light_prescaler #(
   parameter int TICK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // A clear suppresses the tick so a mode load always wins over stepping.
   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/running_light_multi.sv
// rtl/running_light_multi.sv - multi-pattern running-light driver with mode register and step strobe
module running_light_multi
   import running_light_pkg::*;
#(
   parameter int N_LED    = 8,
   parameter int TICK_DIV = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       S,
   output logic [N_LED-1:0] Y,
   output logic             step
);

   localparam int LVL_W = $clog2(N_LED + 1);
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LED);
   localparam logic [N_LED-1:0] Y_LSB = {{(N_LED-1){1'b0}}, 1'b1};
   localparam logic [N_LED-1:0] Y_MSB = {1'b1, {(N_LED-1){1'b0}}};

   mode_e            mode_q;
   dir_e             dir;
   logic [LVL_W-1:0] level;
   logic             mode_chg;
   logic             tick;
   logic [N_LED-1:0] y_nxt;
   dir_e             dir_nxt;
   logic [LVL_W-1:0] lvl_nxt;

   assign mode_chg = (S != mode_q);

   light_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (mode_chg),
      .en   (en),
      .tick (tick)
   );

   // Next pattern on a tick; any state that cannot occur legally falls back to the mode start state.
   always_comb begin
      y_nxt   = Y;
      dir_nxt = dir;
      lvl_nxt = level;
      case (mode_q)
         MODE_ROL: y_nxt = $onehot(Y) ? {Y[N_LED-2:0], Y[N_LED-1]} : Y_LSB;
         MODE_ROR: y_nxt = $onehot(Y) ? {Y[0], Y[N_LED-1:1]} : Y_MSB;
         MODE_BOUNCE: begin
            if (!$onehot(Y) || (dir == DIR_UP && Y[N_LED-1]) || (dir == DIR_DOWN && Y[0])) begin
               y_nxt   = Y_LSB;
               dir_nxt = DIR_UP;
            end else if (dir == DIR_UP) begin
               y_nxt = {Y[N_LED-2:0], 1'b0};
               if (Y[N_LED-2]) dir_nxt = DIR_DOWN;
            end else begin
               y_nxt = {1'b0, Y[N_LED-1:1]};
               if (Y[1]) dir_nxt = DIR_UP;
            end
         end
         MODE_FILL: begin
            if (level > LVL_MAX || (dir == DIR_UP && level == LVL_MAX) ||
                (dir == DIR_DOWN && level == '0)) begin
               lvl_nxt = '0;
               dir_nxt = DIR_UP;
            end else if (dir == DIR_UP) begin
               lvl_nxt = level + LVL_W'(1);
               if (level == LVL_MAX - LVL_W'(1)) dir_nxt = DIR_DOWN;
            end else begin
               lvl_nxt = level - LVL_W'(1);
               if (level == LVL_W'(1)) dir_nxt = DIR_UP;
            end
            for (int i = 0; i < N_LED; i++) begin
               y_nxt[i] = (i < int'(lvl_nxt));
            end
         end
         default: y_nxt = Y_LSB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Y      <= Y_LSB;
         step   <= 1'b0;
         mode_q <= MODE_ROL;
         dir    <= DIR_UP;
         level  <= '0;
      end else if (mode_chg) begin
         mode_q <= mode_e'(S);
         step   <= 1'b0;
         dir    <= DIR_UP;
         level  <= '0;
         case (mode_e'(S))
            MODE_ROL:    Y <= Y_LSB;
            MODE_ROR:    Y <= Y_MSB;
            MODE_BOUNCE: Y <= Y_LSB;
            MODE_FILL:   Y <= '0;
            default:     Y <= Y_LSB;
         endcase
      end else if (tick) begin
         Y     <= y_nxt;
         dir   <= dir_nxt;
         level <= lvl_nxt;
         step  <= 1'b1;
      end else begin
         step <= 1'b0;
      end
   end

endmodule

// File: tb/tb_running_light_multi.sv
// tb/tb_running_light_multi.sv - checks two driver instances (TICK_DIV 2 and 1) against a pattern model
module tb_running_light_multi;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b0;
   logic [1:0]   S   = 2'd0;
   logic [N-1:0] y2, y1;
   logic         step2, step1;

   int errors = 0;
   int checks = 0;

   int   td[2]     = '{2, 1};
   int   m_mode[2] = '{0, 0};
   int   m_k[2]    = '{0, 0};
   int   m_cnt[2]  = '{0, 0};
   logic m_step[2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   running_light_multi #(.N_LED(N), .TICK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .S(S), .Y(y2), .step(step2)
   );

   running_light_multi #(.N_LED(N), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .S(S), .Y(y1), .step(step1)
   );

   // Pattern shown after k steps of mode m, straight from the pattern definitions.
   function automatic logic [N-1:0] pat(int m, int k);
      logic [63:0] one;
      int p;
      int pos;
      one = 64'd1;
      case (m)
         0: pos = k % N;
         1: pos = N - 1 - (k % N);
         2: begin
            p   = k % (2 * N - 2);
            pos = (p < N) ? p : 2 * N - 2 - p;
         end
         default: begin
            p   = k % (2 * N);
            pos = (p <= N) ? p : 2 * N - p;
            return N'((one << pos) - 64'd1);
         end
      endcase
      return N'(one << pos);
   endfunction

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_mode[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_step[i] = 1'b0;
         end else if (int'(S) != m_mode[i]) begin
            m_mode[i] = int'(S); m_k[i] = 0; m_cnt[i] = 0; m_step[i] = 1'b0;
         end else if (en) begin
            if (m_cnt[i] == td[i] - 1) begin
               m_cnt[i] = 0; m_k[i]++; m_step[i] = 1'b1;
            end else begin
               m_cnt[i]++; m_step[i] = 1'b0;
            end
         end else begin
            m_step[i] = 1'b0;
         end
      end
   endtask

   task automatic chk();
      logic [N-1:0] e2, e1;
      e2 = pat(m_mode[0], m_k[0]);
      e1 = pat(m_mode[1], m_k[1]);
      checks++;
      assert (y2 === e2) else begin
         errors++;
         $error("FAIL y_td2 t=%0t observed=%h expected=%h", $time, y2, e2);
      end
      checks++;
      assert (step2 === m_step[0]) else begin
         errors++;
         $error("FAIL step_td2 t=%0t observed=%b expected=%b", $time, step2, m_step[0]);
      end
      checks++;
      assert (y1 === e1) else begin
         errors++;
         $error("FAIL y_td1 t=%0t observed=%h expected=%h", $time, y1, e1);
      end
      checks++;
      assert (step1 === m_step[1]) else begin
         errors++;
         $error("FAIL step_td1 t=%0t observed=%b expected=%b", $time, step1, m_step[1]);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk();
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   initial begin
      bit found;

      // Reset with mode 0 and run enabled
      rst = 1'b1; en = 1'b1; S = 2'd0;
      run(2);
      checks++;
      assert (y2 === 8'h01 && step2 === 1'b0) else begin
         errors++;
         $error("FAIL reset_state observed=%h/%b expected=01/0", y2, step2);
      end
      rst = 1'b0;
      run(40);

      // Each pattern for more than one full period
      S = 2'd1; run(40);
      S = 2'd2; run(60);
      S = 2'd3; run(70);

      // Mode 0 held at 08h, en dropped, mode switched while frozen
      S = 2'd0; cycle();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (pat(m_mode[0], m_k[0]) == 8'h08 && m_step[0]) found = 1'b1;
         else cycle();
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL reach_08 observed=%h expected=08", y2);
      end
      en = 1'b0; run(5);
      checks++;
      assert (y2 === 8'h08) else begin
         errors++;
         $error("FAIL hold_en0 observed=%h expected=08", y2);
      end
      S = 2'd3; cycle();
      checks++;
      assert (y2 === 8'h00) else begin
         errors++;
         $error("FAIL load_fill observed=%h expected=00", y2);
      end
      en = 1'b1; run(6);

      // Reset mid-bounce on the falling pass, landing on a tick cycle
      S = 2'd2; cycle();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if ((m_k[0] % (2 * N - 2)) >= N && m_cnt[0] == td[0] - 1) found = 1'b1;
         else cycle();
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL reach_bounce_down observed=%h expected=falling_pass", y2);
      end
      rst = 1'b1; cycle();
      checks++;
      assert (y2 === 8'h01 && step2 === 1'b0) else begin
         errors++;
         $error("FAIL rst_mid_bounce observed=%h/%b expected=01/0", y2, step2);
      end
      rst = 1'b0; S = 2'd2; run(40);

      // Random en, mode and reset traffic
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) S = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
